// File: rtl/bnn_img_loader.sv
// Streams a 784-bit binary image into the BNN core one byte at a time, fires the start pulse and returns the result.
// Optional WAIT watchdog is enabled by defining BNN_LOADER_TIMEOUT_EN.
module bnn_img_loader #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       img_out [0:783],
    output logic       bnn_write_enable,
    input  logic [7:0] bnn_result_in,
    input  logic       bnn_result_ready,
    output logic [7:0] res_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        OUT
    } state_t;

    state_t       r_state;
    state_t       w_nextState;
    logic [6:0]   r_byteCnt;
    logic [783:0] r_img;
    logic [7:0]   r_resData;
    logic         w_accept;
    logic         w_lastByte;
    logic         w_resultHit;
    logic         w_timeout;

    assign w_accept    = in_valid && (r_state == LOAD);
    assign w_lastByte  = (r_byteCnt == 7'd97);
    assign w_resultHit = bnn_result_ready && (r_state == WAIT);

`ifdef BNN_LOADER_TIMEOUT_EN
    localparam int WdW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdW-1:0] r_wdog;
    logic           r_resErr;

    // Watchdog clears in START so it holds 0 on the first WAIT cycle; a real result on the expiry cycle wins.
    assign w_timeout = (r_state == WAIT) && !bnn_result_ready && (r_wdog == WdW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog   <= '0;
            r_resErr <= 1'b0;
        end else begin
            if (r_state == START) begin
                r_wdog <= '0;
            end else if (r_state == WAIT) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_timeout) begin
                r_resErr <= 1'b1;
            end else if (w_resultHit || ((r_state == OUT) && res_ready)) begin
                r_resErr <= 1'b0;
            end
        end
    end

    assign res_err = r_resErr;
`else
    assign w_timeout = 1'b0;
    assign res_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState      = r_state;
        in_ready         = 1'b0;
        bnn_write_enable = 1'b0;
        res_valid        = 1'b0;
        busy             = 1'b1;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept && w_lastByte) begin
                    w_nextState = START;
                end
            end
            START: begin
                bnn_write_enable = 1'b1;
                w_nextState      = WAIT;
            end
            WAIT: begin
                if (bnn_result_ready || w_timeout) begin
                    w_nextState = OUT;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_nextState = LOAD;
                end
            end
            default: w_nextState = LOAD;
        endcase
    end

    // Image bits only change while loading, so the core sees a frozen image from START until the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byteCnt <= 7'd0;
            r_img     <= '0;
            r_resData <= 8'h00;
        end else begin
            if (w_accept) begin
                r_img[{r_byteCnt, 3'b000} +: 8] <= in_data;
                r_byteCnt <= w_lastByte ? 7'd0 : r_byteCnt + 7'd1;
            end
            if (w_resultHit) begin
                r_resData <= bnn_result_in;
            end else if (w_timeout) begin
                r_resData <= 8'hFF;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 784; i++) begin
            img_out[i] = r_img[i];
        end
    end

    assign res_data = r_resData;

endmodule
